// File: rtl/tm_vector_driver.sv
// rtl/tm_vector_driver.sv - FIFO-buffered vector driver with programmable settle time and sample strobe
// Holds each queued vector on out_vec for HOLD_CYCLES, then strobes capture for one cycle.
module tm_vector_driver #(
  parameter int WIDTH       = 12,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH-1:0]         out_vec,
  output logic                     sample_strobe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, STROBE} state_t;

  state_t            state, state_next;
  logic [HW-1:0]     hold_cnt, hold_next;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              push, pop;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready      = (count < CW'(DEPTH)) && !rst;
  assign push          = in_valid && in_ready;
  assign sample_strobe = (state == STROBE);
  assign busy          = (state != IDLE) || (count != '0);
  assign fifo_count    = count;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    pop        = 1'b0;
    case (state)
      IDLE, STROBE: begin
        if (count != '0) begin
          pop        = 1'b1;
          hold_next  = HW'(HOLD_CYCLES - 1);
          state_next = APPLY;
        end else begin
          state_next = IDLE;
        end
      end
      APPLY: begin
        if (hold_cnt == '0) state_next = STROBE;
        else                hold_next  = hold_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_vec  <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        out_vec <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is always written before count allows its pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
